// File: rtl/inert_pkg.sv
// Shared types and command constants for the inertial sensor SPI front end.
package inert_pkg;

    typedef enum logic [3:0] {
        ST_INIT_WAIT = 4'd0,
        ST_CFG1      = 4'd1,
        ST_CFG2      = 4'd2,
        ST_CFG3      = 4'd3,
        ST_CFG_LAST  = 4'd4,
        ST_IDLE      = 4'd5,
        ST_RD_PL     = 4'd6,
        ST_RD_PH     = 4'd7,
        ST_RD_AL     = 4'd8,
        ST_RD_AH     = 4'd9,
        ST_DONE      = 4'd10
    } inert_state_t;

    // Power-up configuration writes: INT1 data-ready enable, accel/gyro 208 Hz, rounding
    localparam logic [15:0] CMD_INT_EN    = 16'h0D02;
    localparam logic [15:0] CMD_ACCEL_ODR = 16'h1053;
    localparam logic [15:0] CMD_GYRO_ODR  = 16'h1150;
    localparam logic [15:0] CMD_ROUNDING  = 16'h1460;

    // Read addresses already carry the read bit (bit 7)
    localparam logic [7:0] ADDR_PITCH_L = 8'hA2;
    localparam logic [7:0] ADDR_PITCH_H = 8'hA3;
    localparam logic [7:0] ADDR_AZ_L    = 8'hAC;
    localparam logic [7:0] ADDR_AZ_H    = 8'hAD;
    localparam logic [7:0] READ_PAD     = 8'h00;

    function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
        return {addr, READ_PAD};
    endfunction

endpackage

// File: rtl/spi_mnrch_16.sv
// 16-bit SPI master (CPOL=1/CPHA=1): MOSI shifts on SCLK fall, MISO sampled on SCLK rise.
module spi_mnrch_16 #(
    parameter int SCLK_DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    localparam logic [SCLK_DIV_W-1:0] DIV_ONES  = {SCLK_DIV_W{1'b1}};
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE  = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_PORCH = {1'b1, {(SCLK_DIV_W-1){1'b0}}};

    logic                  active_r;
    logic [SCLK_DIV_W-1:0] div_r;
    logic [4:0]            bit_cnt_r;
    logic [15:0]           shft_r;
    logic                  miso_smpl_r;
    logic                  ss_n_r;
    logic                  done_r;
    logic                  rise_s;
    logic                  fall_s;
    logic                  end_s;

    // SCLK edge decode; the first fall (bit count 0) is skipped so the MSB holds through it
    always_comb begin
        rise_s = active_r && (div_r == DIV_RISE);
        fall_s = active_r && (div_r == DIV_ONES) && (bit_cnt_r != 5'd0) && (bit_cnt_r != 5'd16);
        end_s  = active_r && (div_r == DIV_ONES) && (bit_cnt_r == 5'd16);
    end

    // Transaction engine: front porch, 16 SCLK periods, then SS_n release with done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r    <= 1'b0;
            div_r       <= DIV_ONES;
            bit_cnt_r   <= 5'd0;
            shft_r      <= 16'h0000;
            miso_smpl_r <= 1'b0;
            ss_n_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!active_r) begin
                if (wrt) begin
                    active_r  <= 1'b1;
                    ss_n_r    <= 1'b0;
                    div_r     <= DIV_PORCH;
                    bit_cnt_r <= 5'd0;
                    shft_r    <= cmd;
                end
            end else if (end_s) begin
                active_r <= 1'b0;
                ss_n_r   <= 1'b1;
                done_r   <= 1'b1;
                shft_r   <= {shft_r[14:0], miso_smpl_r};
            end else begin
                div_r <= div_r + 1'b1;
                if (rise_s) begin
                    miso_smpl_r <= MISO;
                    bit_cnt_r   <= bit_cnt_r + 5'd1;
                end
                if (fall_s) begin
                    shft_r <= {shft_r[14:0], miso_smpl_r};
                end
            end
        end
    end

    assign SS_n    = ss_n_r;
    assign SCLK    = div_r[SCLK_DIV_W-1];
    assign MOSI    = shft_r[15];
    assign done    = done_r;
    assign rd_data = shft_r;

endmodule

// File: rtl/inert_sensor_intf.sv
// Inertial sensor front end: power-up configuration, then pitch-rate/AZ read bursts on INT.
// Optional stale-data detector enabled by defining INERT_STALE_DET_EN.
module inert_sensor_intf import inert_pkg::*; #(
    parameter int INIT_WAIT_W = 16,
    parameter int SCLK_DIV_W  = 4
`ifdef INERT_STALE_DET_EN
    ,
    parameter int STALE_W     = 20
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
`ifdef INERT_STALE_DET_EN
    output logic        stale,
`endif
    output logic        vld
);

    localparam logic [INIT_WAIT_W-1:0] INIT_ONES = {INIT_WAIT_W{1'b1}};

    inert_state_t           state_r;
    inert_state_t           next_state_s;
    logic                   int_meta_r;
    logic                   int_sync_r;
    logic [INIT_WAIT_W-1:0] init_cnt_r;
    logic                   wrt_s;
    logic [15:0]            cmd_s;
    logic                   done_s;
    logic [15:0]            rd_data_s;
    logic [7:0]             rd_hi_unused_s;
    logic [7:0]             pl_r;
    logic [7:0]             ph_r;
    logic [7:0]             al_r;
    logic [7:0]             ah_r;
    logic [15:0]            ptch_rt_r;
    logic [15:0]            az_r;
    logic                   vld_r;

    spi_mnrch_16 #(
        .SCLK_DIV_W (SCLK_DIV_W)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt_s),
        .cmd     (cmd_s),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (done_s),
        .rd_data (rd_data_s)
    );

    // Only the received low byte carries register data
    assign rd_hi_unused_s = rd_data_s[15:8];

    // Two-flop synchronizer for the asynchronous data-ready interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_r <= 1'b0;
            int_sync_r <= 1'b0;
        end else begin
            int_meta_r <= INT;
            int_sync_r <= int_meta_r;
        end
    end

    // State register and power-up wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT_WAIT;
            init_cnt_r <= {INIT_WAIT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_INIT_WAIT) begin
                init_cnt_r <= init_cnt_r + 1'b1;
            end
        end
    end

    // Next-state and SPI command issue; each transfer is launched on the previous one's done
    always_comb begin
        next_state_s = state_r;
        wrt_s        = 1'b0;
        cmd_s        = 16'h0000;
        case (state_r)
            ST_INIT_WAIT: begin
                if (init_cnt_r == INIT_ONES) begin
                    wrt_s        = 1'b1;
                    cmd_s        = CMD_INT_EN;
                    next_state_s = ST_CFG1;
                end else begin
                    next_state_s = ST_INIT_WAIT;
                end
            end
            ST_CFG1: begin
                if (done_s) begin
                    wrt_s        = 1'b1;
                    cmd_s        = CMD_ACCEL_ODR;
                    next_state_s = ST_CFG2;
                end else begin
                    next_state_s = ST_CFG1;
                end
            end
            ST_CFG2: begin
                if (done_s) begin
                    wrt_s        = 1'b1;
                    cmd_s        = CMD_GYRO_ODR;
                    next_state_s = ST_CFG3;
                end else begin
                    next_state_s = ST_CFG2;
                end
            end
            ST_CFG3: begin
                if (done_s) begin
                    wrt_s        = 1'b1;
                    cmd_s        = CMD_ROUNDING;
                    next_state_s = ST_CFG_LAST;
                end else begin
                    next_state_s = ST_CFG3;
                end
            end
            ST_CFG_LAST: begin
                if (done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CFG_LAST;
                end
            end
            ST_IDLE: begin
                // Level-sensitive: a still-asserted INT starts the next burst at once
                if (int_sync_r) begin
                    wrt_s        = 1'b1;
                    cmd_s        = rd_cmd(ADDR_PITCH_L);
                    next_state_s = ST_RD_PL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD_PL: begin
                if (done_s) begin
                    wrt_s        = 1'b1;
                    cmd_s        = rd_cmd(ADDR_PITCH_H);
                    next_state_s = ST_RD_PH;
                end else begin
                    next_state_s = ST_RD_PL;
                end
            end
            ST_RD_PH: begin
                if (done_s) begin
                    wrt_s        = 1'b1;
                    cmd_s        = rd_cmd(ADDR_AZ_L);
                    next_state_s = ST_RD_AL;
                end else begin
                    next_state_s = ST_RD_PH;
                end
            end
            ST_RD_AL: begin
                if (done_s) begin
                    wrt_s        = 1'b1;
                    cmd_s        = rd_cmd(ADDR_AZ_H);
                    next_state_s = ST_RD_AH;
                end else begin
                    next_state_s = ST_RD_AL;
                end
            end
            ST_RD_AH: begin
                if (done_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RD_AH;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_INIT_WAIT;
            end
        endcase
    end

    // Holding bytes captured as each read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_r <= 8'h00;
            ph_r <= 8'h00;
            al_r <= 8'h00;
            ah_r <= 8'h00;
        end else if (done_s) begin
            case (state_r)
                ST_RD_PL: pl_r <= rd_data_s[7:0];
                ST_RD_PH: ph_r <= rd_data_s[7:0];
                ST_RD_AL: al_r <= rd_data_s[7:0];
                ST_RD_AH: ah_r <= rd_data_s[7:0];
                default:  pl_r <= pl_r;
            endcase
        end
    end

    // Both words update together from one burst, with vld in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_rt_r <= 16'h0000;
            az_r      <= 16'h0000;
            vld_r     <= 1'b0;
        end else begin
            vld_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                ptch_rt_r <= {ph_r, pl_r};
                az_r      <= {ah_r, al_r};
            end
        end
    end

    assign ptch_rt = ptch_rt_r;
    assign AZ      = az_r;
    assign vld     = vld_r;

`ifdef INERT_STALE_DET_EN
    localparam logic [STALE_W-1:0] STALE_ONES = {STALE_W{1'b1}};

    logic [STALE_W-1:0] stale_cnt_r;
    logic               stale_r;

    // Idle-time counter; cleared as a burst publishes so stale drops on the vld cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt_r <= {STALE_W{1'b0}};
            stale_r     <= 1'b0;
        end else if (state_r == ST_DONE) begin
            stale_cnt_r <= {STALE_W{1'b0}};
            stale_r     <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (stale_cnt_r == STALE_ONES) begin
                stale_r <= 1'b1;
            end else begin
                stale_cnt_r <= stale_cnt_r + 1'b1;
            end
        end
    end

    assign stale = stale_r;
`endif

endmodule
